// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: widths, ALU
// selects, funct3 codes, FSM states and small decode helpers.
package muldiv_sequencer_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // ALU select codes (shared with the decode stage)
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // RV32M funct3 codes handled here
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    // Legal codes are MUL (000) and the divide/remainder group (1xx)
    function automatic logic op_is_legal(input logic [2:0] f3);
        return (f3 == F3_MUL) || f3[2];
    endfunction

    function automatic logic op_is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    // Two's-complement negation; 0x80000000 maps to itself
    function automatic word_t negate(input word_t x);
        return ~x + word_t'(1);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the sequencer.
interface muldiv_sequencer_if
    import muldiv_sequencer_pkg::*;
();
    logic       start;
    logic [2:0] op;
    word_t      rs1;
    word_t      rs2;
    logic       busy;
    logic       done;
    word_t      result;
    logic       illegal;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/muldiv_sequencer_alu.sv
// Minimal add/subtract ALU; unegative flags an unsigned borrow on subtract.
module alu_module
    import muldiv_sequencer_pkg::*;
(
    input  word_t      op1,
    input  word_t      op2,
    input  logic [3:0] sel,
    output word_t      res,
    output logic       zero,
    output logic       negative,
    output logic       unegative
);
    logic [XLEN:0] diff;

    // Select the arithmetic result and the unsigned borrow
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        diff      = {1'b0, op1} - {1'b0, op2};
        res       = '0;
        unegative = 1'b0;
        case (sel)
            ALU_ADD: res = op1 + op2;
            ALU_SUB: begin
                res       = diff[XLEN-1:0];
                unegative = diff[XLEN];
            end
            default: ;
        endcase
    end

    assign zero     = (res == '0);
    assign negative = res[XLEN-1];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit (MUL/DIV/DIVU/REM/REMU): shift-add multiply and
// restoring divide, one bit per cycle through a single shared ALU.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);
    state_t     state, state_nxt;
    logic [2:0] op_q;
    word_t      opa;        // multiplicand / dividend, quotient shifts in here
    word_t      opb;        // multiplier / divisor
    word_t      acc;        // product accumulator / partial remainder
    logic [4:0] cnt;
    logic       sign_a, sign_b;
    word_t      result_q;
    logic       illegal_q;

    logic       accept;
    logic       special;
    word_t      special_res;
    word_t      fix_res;
    word_t      sh;
    logic       carry, qbit;
    word_t      alu_op1, alu_op2, alu_res;
    logic [3:0] alu_sel;
    logic       alu_uneg;
    logic       alu_zero_unused, alu_negative_unused;

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

    alu_module u_alu (
        .op1       (alu_op1),
        .op2       (alu_op2),
        .sel       (alu_sel),
        .res       (alu_res),
        .zero      (alu_zero_unused),
        .negative  (alu_negative_unused),
        .unegative (alu_uneg)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_PREP;
            ST_PREP: state_nxt = special ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt == 5'd0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = accept ? ST_PREP : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs and ALU operand steering
    always_comb begin
        bus.busy = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
        bus.done = (state == ST_DONE);
        sh       = {acc[XLEN-2:0], opa[XLEN-1]};
        carry    = acc[XLEN-1];
        if (op_q == F3_MUL) begin
            alu_sel = ALU_ADD;
            alu_op1 = acc;
            alu_op2 = opb[0] ? opa : '0;
        end else begin
            alu_sel = ALU_SUB;
            alu_op1 = sh;
            alu_op2 = opb;
        end
        // With carry set the true 33-bit value exceeds any divisor, so subtract
        qbit = carry | ~alu_uneg;
    end

    // Special-case detection on the latched (pre-abs) operands
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (!op_is_legal(op_q)) begin
            special = 1'b1;
        end else if ((op_q != F3_MUL) && (opb == '0)) begin
            special     = 1'b1;
            special_res = op_is_rem(op_q) ? opa : '1;
        end else if (op_is_signed(op_q) && (opa == 32'h8000_0000) && (opb == '1)) begin
            special     = 1'b1;
            special_res = op_is_rem(op_q) ? '0 : 32'h8000_0000;
        end
    end

    // Sign correction applied in FIX
    always_comb begin
        if (op_q == F3_MUL)
            fix_res = acc;
        else if (op_is_rem(op_q))
            fix_res = (op_is_signed(op_q) && sign_a) ? negate(acc) : acc;
        else
            fix_res = (op_is_signed(op_q) && (sign_a ^ sign_b)) ? negate(opa) : opa;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, so an abort leaves nothing stale behind.
        if (rst) begin
            op_q      <= '0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q      <= bus.op;
                        opa       <= bus.rs1;
                        opb       <= bus.rs2;
                        illegal_q <= 1'b0;
                    end
                end
                ST_PREP: begin
                    sign_a <= op_is_signed(op_q) & opa[XLEN-1];
                    sign_b <= op_is_signed(op_q) & opb[XLEN-1];
                    if (op_is_signed(op_q)) begin
                        opa <= opa[XLEN-1] ? negate(opa) : opa;
                        opb <= opb[XLEN-1] ? negate(opb) : opb;
                    end
                    if (special) begin
                        result_q  <= special_res;
                        illegal_q <= !op_is_legal(op_q);
                    end
                    acc <= '0;
                    cnt <= 5'd31;
                end
                ST_RUN: begin
                    cnt <= cnt - 5'd1;
                    if (op_q == F3_MUL) begin
                        acc <= alu_res;
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end else begin
                        acc <= qbit ? alu_res : sh;
                        opa <= {opa[XLEN-2:0], qbit};
                    end
                end
                ST_FIX: result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issue one op at edge 0 and report the cycle done is seen in (-1 on timeout).
    // shape_ok clears if busy drops before done, busy is high with done, or done lasts >1 cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat,
                          output logic shape_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = f3;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        lat      = -1;
        shape_ok = 1'b1;
        res      = 32'hDEAD_BEEF;
        ill      = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.op    = F3_DIV;
                bus.rs1   = 32'h1234_5678;
                bus.rs2   = 32'h0000_0003;
            end
            if (bus.done) begin
                lat = c;
                res = bus.result;
                ill = bus.illegal;
                if (bus.busy) shape_ok = 1'b0;
                break;
            end else if (!bus.busy) begin
                shape_ok = 1'b0;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            if (bus.done || bus.busy) shape_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset_busy got %b expected 0", bus.busy); errors++;
        end
        checks++;
        if (bus.done !== 1'b0) begin
            $display("FAIL reset_done got %b expected 0", bus.done); errors++;
        end
        checks++;
        if (bus.result !== 32'h0) begin
            $display("FAIL reset_result got %h expected 00000000", bus.result); errors++;
        end
        checks++;
        if (bus.illegal !== 1'b0) begin
            $display("FAIL reset_illegal got %b expected 0", bus.illegal); errors++;
        end
        rst = 1'b0;
    endtask

    // Full-length ops: MUL and the four divide flavours, all with latency 35
    task automatic test_arith();
        logic [2:0]  f3s [8] = '{F3_MUL, F3_MUL, F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
        logic [31:0] as  [8] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100};
        logic [31:0] bs  [8] = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                 32'h8000_0001, 32'h8000_0001, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] exp [8] = '{32'd42, 32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'h0000_0001, 32'h7FFF_FFFE, 32'hFFFF_FFF2, 32'h0000_0002};
        logic [31:0] res;
        logic        ill, shape_ok;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            run_op(f3s[i], as[i], bs[i], res, ill, lat, shape_ok);
            checks++;
            if (res !== exp[i]) begin
                $display("FAIL arith[%0d]_result got %h expected %h", i, res, exp[i]); errors++;
            end
            checks++;
            if (lat != 35) begin
                $display("FAIL arith[%0d]_latency got %0d expected 35", i, lat); errors++;
            end
            checks++;
            if (ill !== 1'b0 || shape_ok !== 1'b1) begin
                $display("FAIL arith[%0d]_flags got illegal=%b shape=%b expected illegal=0 shape=1",
                         i, ill, shape_ok); errors++;
            end
        end
    endtask

    // Divide-by-zero, signed overflow and illegal funct3 finish in cycle 2
    task automatic test_special();
        logic [2:0]  f3s [6] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, 3'b001, 3'b011};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
        logic        eil [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] res;
        logic        ill, shape_ok;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(f3s[i], as[i], bs[i], res, ill, lat, shape_ok);
            checks++;
            if (res !== exp[i]) begin
                $display("FAIL special[%0d]_result got %h expected %h", i, res, exp[i]); errors++;
            end
            checks++;
            if (lat != 2) begin
                $display("FAIL special[%0d]_latency got %0d expected 2", i, lat); errors++;
            end
            checks++;
            if (ill !== eil[i] || shape_ok !== 1'b1) begin
                $display("FAIL special[%0d]_flags got illegal=%b shape=%b expected illegal=%b shape=1",
                         i, ill, shape_ok, eil[i]); errors++;
            end
        end
    endtask

    // start in RUN is ignored; start held in DONE issues the next op at once
    task automatic test_back_to_back();
        int lat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = F3_MUL; bus.rs1 = 32'd7; bus.rs2 = 32'd6;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 5) begin
                bus.start = 1'b1; bus.op = F3_DIV; bus.rs1 = 32'd100; bus.rs2 = 32'd3;
            end
            if (c == 6) bus.start = 1'b0;
            if (bus.done) begin lat = c; break; end
        end
        checks++;
        if (lat != 35 || bus.result !== 32'd42) begin
            $display("FAIL b2b_first got lat=%0d result=%h expected lat=35 result=0000002a",
                     lat, bus.result); errors++;
        end
        bus.start = 1'b1; bus.op = F3_MUL; bus.rs1 = 32'd5; bus.rs2 = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            $display("FAIL b2b_prep got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
            errors++;
        end
        lat = -1;
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done) begin lat = c; break; end
        end
        checks++;
        if (lat != 35 || bus.result !== 32'd25) begin
            $display("FAIL b2b_second got lat=%0d result=%h expected lat=35 result=00000019",
                     lat, bus.result); errors++;
        end
        @(negedge clk);
    endtask

    // Reset in cycle 10 of a DIV aborts it with no trailing done
    task automatic test_reset_mid();
        logic [31:0] res;
        logic        ill, shape_ok;
        int          lat;
        logic        seen_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = F3_DIV; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL abort_pre_busy got %b expected 1", bus.busy); errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            $display("FAIL abort_outputs got busy=%b done=%b result=%h expected 0 0 00000000",
                     bus.busy, bus.done, bus.result); errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            $display("FAIL abort_quiet got activity=%b expected 0", seen_done); errors++;
        end
        run_op(F3_MUL, 32'd3, 32'd3, res, ill, lat, shape_ok);
        checks++;
        if (res !== 32'd9 || lat != 35) begin
            $display("FAIL abort_then_mul got lat=%0d result=%h expected lat=35 result=00000009",
                     lat, res); errors++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = F3_MUL;
        bus.rs1   = '0;
        bus.rs2   = '0;
        test_reset();
        test_arith();
        test_special();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
